// File: rtl/program_loader.sv
// rtl/program_loader.sv - filters BeeF command bytes into instruction memory, appends a halt
// terminator and holds the core in reset until a balanced program fits.
module program_loader #(
    parameter int ADDR_W  = 10,
    parameter int DEPTH_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [7:0]        imem_data,
    output logic [ADDR_W:0]   prog_len,
    output logic              core_reset,
    output logic              load_done,
    output logic              load_error,
    output logic [1:0]        error_code
);

    localparam logic [ADDR_W-1:0]  COUNT_MAX = '1;
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

    localparam logic [1:0] ERR_CLOSE    = 2'd1;
    localparam logic [1:0] ERR_OPEN     = 2'd2;
    localparam logic [1:0] ERR_OVERFLOW = 2'd3;

    typedef enum logic [1:0] {LOAD, TERM, DONE, ERROR} state_t;

    state_t             state, state_next;
    logic [ADDR_W-1:0]  count, count_next;
    logic [DEPTH_W-1:0] depth, depth_next;
    logic               we_next;
    logic [ADDR_W-1:0]  addr_next;
    logic [7:0]         data_next;
    logic [1:0]         code_next;
    logic               is_cmd;
    logic               accept;

    assign in_ready = (state == LOAD) && !reset;
    assign accept   = in_valid && in_ready;

    always_comb begin
        is_cmd = 1'b0;
        case (in_data)
            8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h5B, 8'h5D, 8'h2E, 8'h2C: is_cmd = 1'b1;
            default: is_cmd = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        count_next = count;
        depth_next = depth;
        we_next    = 1'b0;
        addr_next  = count;
        data_next  = in_data;
        code_next  = error_code;

        case (state)
            LOAD: begin
                if (accept) begin
                    // A byte that fails its own checks is never written and masks in_last.
                    if (is_cmd && count == COUNT_MAX) begin
                        state_next = ERROR;
                        code_next  = ERR_OVERFLOW;
                    end else if (in_data == 8'h5B && depth == DEPTH_MAX) begin
                        state_next = ERROR;
                        code_next  = ERR_OVERFLOW;
                    end else if (in_data == 8'h5D && depth == '0) begin
                        state_next = ERROR;
                        code_next  = ERR_CLOSE;
                    end else begin
                        if (is_cmd) begin
                            we_next    = 1'b1;
                            count_next = count + 1'b1;
                            if (in_data == 8'h5B) depth_next = depth + 1'b1;
                            if (in_data == 8'h5D) depth_next = depth - 1'b1;
                        end
                        if (in_last) begin
                            if (depth_next != '0) begin
                                state_next = ERROR;
                                code_next  = ERR_OPEN;
                            end else begin
                                state_next = TERM;
                            end
                        end
                    end
                end
            end
            TERM: begin
                we_next    = 1'b1;
                data_next  = 8'h00;
                state_next = DONE;
            end
            DONE:    state_next = DONE;
            ERROR:   state_next = ERROR;
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= LOAD;
            count      <= '0;
            depth      <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_data  <= 8'h00;
            prog_len   <= '0;
            core_reset <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            error_code <= 2'd0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            depth   <= depth_next;
            imem_we <= we_next;
            if (we_next) begin
                imem_addr <= addr_next;
                imem_data <= data_next;
            end
            prog_len   <= {1'b0, count_next};
            // Release lags DONE by one cycle so the terminator write lands first.
            core_reset <= (state != DONE);
            load_done  <= (state == DONE);
            load_error <= (state_next == ERROR);
            error_code <= code_next;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized and directed checks of program_loader against a reference model.
module tb_program_loader;

    localparam int ADDR_W  = 4;
    localparam int DEPTH_W = 2;
    localparam int CAP     = 1 << ADDR_W;
    localparam int DMAX    = (1 << DEPTH_W) - 1;

    typedef logic [7:0] byte_q_t[$];

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [7:0]        imem_data;
    logic [ADDR_W:0]   prog_len;
    logic              core_reset;
    logic              load_done;
    logic              load_error;
    logic [1:0]        error_code;

    int passed = 0;
    int total  = 0;
    int wq[$];

    program_loader #(.ADDR_W(ADDR_W), .DEPTH_W(DEPTH_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_data(imem_data),
        .prog_len(prog_len), .core_reset(core_reset), .load_done(load_done),
        .load_error(load_error), .error_code(error_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we === 1'b1) wq.push_back({imem_addr, imem_data});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic byte_q_t to_q(input string s);
        byte_q_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    function automatic bit is_command(input logic [7:0] b);
        return b == "+" || b == "-" || b == "<" || b == ">" ||
               b == "[" || b == "]" || b == "." || b == ",";
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        @(negedge clk);
        chk("ready_in_reset", in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_we", imem_we, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_data", imem_data, 0);
        chk("rst_len", prog_len, 0);
        chk("rst_core_reset", core_reset, 1);
        chk("rst_done", load_done, 0);
        chk("rst_error", load_error, 0);
        chk("rst_code", error_code, 0);
        #1;
        chk("ready_after_reset", in_ready, 1);
    endtask

    task automatic run_test(input string name, input byte_q_t q, input bit last);
        int exp_w[$];
        int cnt = 0, dep = 0, consumed = 0, code = 0, i = 0, guard = 0;
        bit done = 0;

        // Reference: walk the stream with the loader's rules on plain integers.
        foreach (q[j]) begin
            logic [7:0] b = q[j];
            consumed = j + 1;
            if (is_command(b)) begin
                if (cnt == CAP - 1) begin code = 3; break; end
                if (b == "[" && dep == DMAX) begin code = 3; break; end
                if (b == "]" && dep == 0) begin code = 1; break; end
                exp_w.push_back({cnt[ADDR_W-1:0], b});
                cnt++;
                if (b == "[") dep++;
                if (b == "]") dep--;
            end
            if (last && j == q.size() - 1) begin
                if (dep != 0) code = 2;
                else begin
                    exp_w.push_back({cnt[ADDR_W-1:0], 8'h00});
                    done = 1;
                end
            end
        end

        do_reset();
        wq.delete();

        forever begin
            @(negedge clk);
            if (i == q.size() || !in_ready || guard > 500) begin
                in_valid = 1'b0;
                in_last = 1'b0;
                break;
            end
            guard++;
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
            end else begin
                bit acc;
                in_valid = 1'b1;
                in_data = q[i];
                in_last = last && (i == q.size() - 1);
                #1;
                acc = in_ready;
                @(posedge clk);
                if (acc) i++;
            end
        end

        chk({name, "_consumed"}, i, consumed);
        if (done) begin
            chk({name, "_done_k1"}, load_done, 0);
            @(negedge clk);
            chk({name, "_term_we"}, imem_we, 1);
            chk({name, "_term_addr"}, imem_addr, cnt);
            chk({name, "_term_data"}, imem_data, 0);
            chk({name, "_done_k2"}, load_done, 0);
            @(negedge clk);
            chk({name, "_done_k3"}, load_done, 1);
            chk({name, "_core_rel_k3"}, core_reset, 0);
        end else if (code != 0) begin
            chk({name, "_err_k1"}, load_error, 1);
            chk({name, "_code_k1"}, error_code, code);
        end

        if (done || code != 0) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                in_valid = 1'b1;
                in_data = "+";
                in_last = 1'b0;
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
        repeat (2) @(negedge clk);

        chk({name, "_nwrites"}, wq.size(), exp_w.size());
        for (int w = 0; w < exp_w.size() && w < wq.size(); w++)
            chk($sformatf("%s_write%0d", name, w), wq[w], exp_w[w]);
        chk({name, "_len"}, prog_len, cnt);
        chk({name, "_done"}, load_done, done);
        chk({name, "_error"}, load_error, code != 0);
        chk({name, "_code"}, error_code, code);
        chk({name, "_core_reset"}, core_reset, !done);
        chk({name, "_ready"}, in_ready, !done && code == 0);
    endtask

    initial begin
        byte_q_t q;
        string s;

        run_test("basic", to_q("+[->+<]."), 1);
        run_test("comments", to_q("a+ b\n-"), 1);
        run_test("unmatched_close", to_q("+]"), 0);
        run_test("unmatched_open", to_q("[[+]"), 1);
        run_test("max_depth_ok", to_q("[[[]]]"), 1);
        run_test("depth_overflow", to_q("[[[["), 1);

        s = "";
        for (int k = 0; k < CAP; k++) s = {s, "+"};
        run_test("cap_overflow", to_q(s), 1);
        s = "";
        for (int k = 0; k < CAP - 1; k++) s = {s, "+"};
        run_test("cap_exact", to_q(s), 1);
        run_test("cap_noise_last", to_q({s, "x"}), 1);

        run_test("partial", to_q("+-<"), 0);
        run_test("after_reset", to_q(".,"), 1);
        run_test("close_last", to_q("]"), 1);

        for (int t = 0; t < 30; t++) begin
            string pool;
            int len;
            pool = "+-<>[].,[]ab \n";
            q.delete();
            len = $urandom_range(1, 20);
            for (int k = 0; k < len; k++) q.push_back(pool[$urandom_range(0, pool.len() - 1)]);
            run_test($sformatf("rand%0d", t), q, 1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
